// File: rtl/jt900h_divn.sv
// jt900h_divn: multi-cycle restoring divider, 2W/W (full) or W/(W/2) (half), signed or unsigned.
// Define JT900H_DIV_RADIX4_EN to resolve two quotient bits per cen cycle.
module jt900h_divn #(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen_i,
  input  logic [2*W-1:0] op0_i,
  input  logic [W-1:0]   op1_i,
  input  logic           len_i,
  input  logic           sign_i,
  input  logic           start_i,
  output logic [W-1:0]   quot_o,
  output logic [W-1:0]   rem_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           v_o
);
  localparam int unsigned H  = W / 2;
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic {StIdle, StRun} state_e;
  state_e state_q, state_d;

  logic [W-1:0]  quot_q, quot_d, rem_q, rem_d;
  logic          busy_q, busy_d, done_q, done_d, v_q, v_d, start_l_q;
  logic [W-1:0]  div_q, div_d, pr_q, pr_d, dl_q, dl_d, qt_q, qt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          len_q, len_d, sign_q, sign_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic          ovf_q, ovf_d, zero_q, zero_d;

  // Operand magnitudes and initial partial remainder, computed from the live inputs
  logic           accept, s0, s1, zero_n;
  logic [2*W-1:0] dvd_full;
  logic [W-1:0]   dvd_half, dvs_full, pr_n, dl_n, div_n;
  logic [H-1:0]   dvs_half;

  assign accept = start_i & ~start_l_q & ~busy_q;

  always_comb begin
    s0       = sign_i & (len_i ? op0_i[2*W-1] : op0_i[W-1]);
    s1       = sign_i & (len_i ? op1_i[W-1] : op1_i[H-1]);
    dvd_full = s0 ? ({(2*W){1'b0}} - op0_i) : op0_i;
    dvd_half = s0 ? ({W{1'b0}} - op0_i[W-1:0]) : op0_i[W-1:0];
    dvs_full = s1 ? ({W{1'b0}} - op1_i) : op1_i;
    dvs_half = s1 ? ({H{1'b0}} - op1_i[H-1:0]) : op1_i[H-1:0];
    zero_n   = len_i ? (op1_i == '0) : (op1_i[H-1:0] == '0);
    div_n    = len_i ? dvs_full : {{H{1'b0}}, dvs_half};
    pr_n     = len_i ? dvd_full[2*W-1:W] : {{H{1'b0}}, dvd_half[W-1:H]};
    // On divide-by-zero the shift register carries the raw dividend through to rem
    if (zero_n) dl_n = len_i ? op0_i[W-1:0] : {{H{1'b0}}, op0_i[H-1:0]};
    else        dl_n = len_i ? dvd_full[W-1:0] : {dvd_half[H-1:0], {H{1'b0}}};
  end

  // First compare/subtract stage
  logic [W:0]    sh1;
  logic          ge1;
  logic [W-1:0]  pr1, qt1, dl1, pr_s, qt_s, dl_s;
  logic [CW-1:0] step;

  always_comb begin
    sh1 = {pr_q, dl_q[W-1]};
    ge1 = sh1 >= {1'b0, div_q};
    pr1 = ge1 ? W'(sh1 - {1'b0, div_q}) : sh1[W-1:0];
    qt1 = W'({qt_q, ge1});
    dl1 = dl_q << 1;
  end

`ifdef JT900H_DIV_RADIX4_EN
  logic [W:0]   sh2;
  logic         ge2;
  logic [W-1:0] pr2, qt2, dl2;

  always_comb begin
    sh2 = {pr1, dl1[W-1]};
    ge2 = sh2 >= {1'b0, div_q};
    pr2 = ge2 ? W'(sh2 - {1'b0, div_q}) : sh2[W-1:0];
    qt2 = W'({qt1, ge2});
    dl2 = dl1 << 1;
    // An odd iteration count finishes with a single stage
    if (cnt_q >= CW'(2)) begin
      pr_s = pr2;
      qt_s = qt2;
      dl_s = dl2;
      step = CW'(2);
    end else begin
      pr_s = pr1;
      qt_s = qt1;
      dl_s = dl1;
      step = CW'(1);
    end
  end
`else
  assign pr_s = pr1;
  assign qt_s = qt1;
  assign dl_s = dl1;
  assign step = CW'(1);
`endif

  // Sign correction and signed-range check, folded into the last iteration
  logic [W-1:0] qf, rf, q_fin, r_fin;
  logic [H-1:0] qh, rh;
  logic         sovf;

  always_comb begin
    qf    = qneg_q ? ({W{1'b0}} - qt_s) : qt_s;
    rf    = rneg_q ? ({W{1'b0}} - pr_s) : pr_s;
    qh    = qneg_q ? ({H{1'b0}} - qt_s[H-1:0]) : qt_s[H-1:0];
    rh    = rneg_q ? ({H{1'b0}} - pr_s[H-1:0]) : pr_s[H-1:0];
    q_fin = len_q ? qf : {{H{1'b0}}, qh};
    r_fin = len_q ? rf : {{H{1'b0}}, rh};
    sovf  = len_q ? (qt_s[W-1] & (~qneg_q | (|qt_s[W-2:0])))
                  : (qt_s[H-1] & (~qneg_q | (|qt_s[H-2:0])));
  end

  always_comb begin
    state_d = state_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    v_d     = v_q;
    div_d   = div_q;
    pr_d    = pr_q;
    dl_d    = dl_q;
    qt_d    = qt_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sign_d  = sign_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          busy_d  = 1'b1;
          len_d   = len_i;
          sign_d  = sign_i;
          qneg_d  = s0 ^ s1;
          rneg_d  = s0;
          zero_d  = zero_n;
          div_d   = div_n;
          pr_d    = pr_n;
          dl_d    = dl_n;
          qt_d    = '0;
          // High half already >= divisor means the quotient cannot fit
          ovf_d   = pr_n >= div_n;
          cnt_d   = len_i ? CW'(W) : CW'(H);
        end
      end
      StRun: begin
        if (zero_q) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          v_d     = 1'b1;
          quot_d  = '1;
          rem_d   = dl_q;
          cnt_d   = '0;
        end else begin
          pr_d  = pr_s;
          qt_d  = qt_s;
          dl_d  = dl_s;
          cnt_d = cnt_q - step;
          if (cnt_q == step) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            quot_d  = q_fin;
            rem_d   = r_fin;
            v_d     = ovf_q | (sign_q & sovf);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      quot_q    <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      v_q       <= 1'b0;
      start_l_q <= 1'b0;
      div_q     <= '0;
      pr_q      <= '0;
      dl_q      <= '0;
      qt_q      <= '0;
      cnt_q     <= '0;
      len_q     <= 1'b0;
      sign_q    <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else if (cen_i) begin
      state_q   <= state_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      v_q       <= v_d;
      start_l_q <= start_i;
      div_q     <= div_d;
      pr_q      <= pr_d;
      dl_q      <= dl_d;
      qt_q      <= qt_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      sign_q    <= sign_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign v_o    = v_q;

endmodule
